// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the full-adder helper equations used by the one-bit adder cell.
package serial_adder_ctrl_pkg;

   // Controller states. Code 2'b11 is unused and falls back to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_FIN   = 2'b10
   } state_t;

   // Supported operand widths.
   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 32;

   // Sum bit of a one-bit full adder.
   function automatic logic fa_sum(input logic a, input logic b, input logic c);
      return a ^ b ^ c;
   endfunction

   // Carry out of a one-bit full adder (majority of the three inputs).
   function automatic logic fa_carry(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// Combinational one-bit full adder cell driven by the serial adder controller.
module fa_bit
   import serial_adder_ctrl_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = fa_sum(a, b, ci);
   assign co = fa_carry(a, b, ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: captures two operands and a carry-in, feeds
// one bit pair per clock (LSB first) through a single full-adder cell with a
// registered carry loop, and publishes the collected sum and final carry.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
)
(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
);

   localparam int unsigned     CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_s;
   logic             fa_co;

   // The single adder cell always looks at the operand LSBs and the carry flop.
   fa_bit u_fa_bit (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // Next-state, datapath and output-register logic; everything holds by default.
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               a_sh_d  = A;
               b_sh_d  = B;
               carry_d = CIN;
               cnt_d   = {CW{1'b0}};
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SHIFT: begin
            // One bit per edge: sum bit enters at the MSB so that after
            // WIDTH edges the LSB-first stream lines up as a normal word.
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
            carry_d = fa_co;
            if (cnt_q == LAST_BIT) begin
               // Final bit: publish the finished word and carry directly
               // from the cell so SUM/COUT update on the same edge as DONE.
               sum_d   = {fa_s, res_q[WIDTH-1:1]};
               cout_d  = fa_co;
               cnt_d   = {CW{1'b0}};
               done_d  = 1'b1;
               state_d = ST_FIN;
            end else begin
               cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end

         ST_FIN: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         a_sh_q  <= {WIDTH{1'b0}};
         b_sh_q  <= {WIDTH{1'b0}};
         res_q   <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign SUM  = sum_q;
   assign COUT = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2.
// Expected results come from plain integer addition pushed into queues;
// independent monitors pop and compare on every DONE pulse.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0;
   logic [7:0] a8 = 8'h00, b8 = 8'h00;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start2 = 1'b0;
   logic [1:0] a2 = 2'b00, b2 = 2'b00;
   logic       cin2 = 1'b0;
   logic       busy2, done2, cout2;
   logic [1:0] sum2;

   int checks = 0;
   int errors = 0;

   logic [8:0] q8[$];
   logic [2:0] q2[$];
   logic [8:0] e8;
   logic [2:0] e2;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8), .CIN(cin8),
      .BUSY(busy8), .DONE(done8), .SUM(sum8), .COUT(cout8)
   );

   serial_adder_ctrl #(.WIDTH(2)) dut2 (
      .CLK(clk), .RST_N(rst_n), .START(start2), .A(a2), .B(b2), .CIN(cin2),
      .BUSY(busy2), .DONE(done2), .SUM(sum2), .COUT(cout2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // WIDTH=8 monitor: every DONE must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done8_unexpected: DONE pulse with no operation outstanding at %0t", $time);
         end else begin
            e8 = q8.pop_front();
            chk("sum8", {24'd0, sum8}, {24'd0, e8[7:0]});
            chk("cout8", {31'd0, cout8}, {31'd0, e8[8]});
         end
      end
   end

   // WIDTH=2 monitor.
   always @(negedge clk) begin
      if (done2 === 1'b1) begin
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done2_unexpected: DONE pulse with no operation outstanding at %0t", $time);
         end else begin
            e2 = q2.pop_front();
            chk("sum2", {30'd0, sum2}, {30'd0, e2[1:0]});
            chk("cout2", {31'd0, cout2}, {31'd0, e2[2]});
         end
      end
   end

   // Present one request; returns at the falling edge just after acceptance.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit expect_result);
      @(negedge clk);
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
      if (expect_result) q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic c);
      @(negedge clk);
      a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
      q2.push_back({1'b0, a} + {1'b0, b} + {2'd0, c});
      @(negedge clk);
      start2 = 1'b0;
   endtask

   // Wait (bounded) until DONE is visible; optionally scramble the operand pins meanwhile.
   task automatic wait_done8(input bit scramble);
      int n = 0;
      while (done8 !== 1'b1 && n < 20) begin
         if (scramble) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         end
         @(negedge clk);
         n++;
      end
      checks++;
      if (done8 !== 1'b1) begin
         errors++;
         $display("FAIL done8_timeout: DONE not seen within 20 cycles at %0t", $time);
      end
   endtask

   task automatic wait_done2(input bit scramble);
      int n = 0;
      while (done2 !== 1'b1 && n < 20) begin
         if (scramble) begin
            a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
         end
         @(negedge clk);
         n++;
      end
      checks++;
      if (done2 !== 1'b1) begin
         errors++;
         $display("FAIL done2_timeout: DONE not seen within 20 cycles at %0t", $time);
      end
   endtask

   initial begin
      bit saw_done;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_sum8", {24'd0, sum8}, 32'd0);
      chk("rst_cout8", {31'd0, cout8}, 32'd0);
      chk("rst_busy8", {31'd0, busy8}, 32'd0);
      chk("rst_done8", {31'd0, done8}, 32'd0);
      chk("rst_sum2", {30'd0, sum2}, 32'd0);
      chk("rst_busy2", {31'd0, busy2}, 32'd0);
      rst_n = 1'b1;

      // Basic add with cycle-accurate BUSY/DONE window.
      issue8(8'h35, 8'h4A, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk("basic_busy", {31'd0, busy8}, 32'd1);
         chk("basic_no_done", {31'd0, done8}, 32'd0);
         @(negedge clk);
      end
      chk("basic_done_pulse", {31'd0, done8}, 32'd1);
      chk("basic_busy_low", {31'd0, busy8}, 32'd0);
      chk("basic_sum_7f", {24'd0, sum8}, 32'h7F);
      @(negedge clk);
      chk("basic_done_one_cycle", {31'd0, done8}, 32'd0);

      // Carry ripples through every bit.
      issue8(8'hFF, 8'h01, 1'b0, 1'b1);
      wait_done8(1'b0);
      issue8(8'hFF, 8'hFF, 1'b1, 1'b1);
      wait_done8(1'b0);

      // Output hold: SUM keeps 8'h46 while the next operation shifts.
      issue8(8'h12, 8'h34, 1'b0, 1'b1);
      wait_done8(1'b0);
      issue8(8'hF0, 8'h0F, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk("hold_sum_46", {24'd0, sum8}, 32'h46);
         @(negedge clk);
      end
      chk("hold_done", {31'd0, done8}, 32'd1);
      chk("hold_new_sum", {24'd0, sum8}, 32'h00);

      // START held high with operand pins changing during SHIFT.
      @(negedge clk);
      a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
      q8.push_back(9'h033);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         chk("held_busy", {31'd0, busy8}, 32'd1);
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         @(negedge clk);
      end
      chk("held_done", {31'd0, done8}, 32'd1);
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
      q8.push_back(9'h101);
      @(negedge clk);
      chk("held_no_accept_in_fin", {31'd0, busy8}, 32'd0);
      @(negedge clk);
      chk("held_reaccept_k10", {31'd0, busy8}, 32'd1);
      start8 = 1'b0;
      wait_done8(1'b0);

      // Reset in the middle of SHIFT aborts without a DONE pulse.
      issue8(8'h5A, 8'h3C, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_sum", {24'd0, sum8}, 32'd0);
      chk("abort_cout", {31'd0, cout8}, 32'd0);
      chk("abort_busy", {31'd0, busy8}, 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done8 === 1'b1) saw_done = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_done", {31'd0, saw_done}, 32'd0);
      issue8(8'h9C, 8'h2B, 1'b0, 1'b1);
      wait_done8(1'b0);

      // Random sweep, WIDTH=8.
      for (int n = 0; n < 1000; n++) begin
         issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
         wait_done8(1'b1);
         repeat ($urandom_range(2, 0)) @(negedge clk);
      end

      // Random sweep, WIDTH=2.
      for (int n = 0; n < 1000; n++) begin
         issue2(2'($urandom), 2'($urandom), 1'($urandom));
         wait_done2(1'b1);
         repeat ($urandom_range(2, 0)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("q8_drained", q8.size(), 32'd0);
      chk("q2_drained", q2.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
